accum_stream_driver: RTL
========================

ACCUM_STREAM_DRIVER -- requirements
Module: accum_stream_driver

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, word width (IEEE-754 single-precision data).
REQ-002 SHALL provide parameter ADDR_WIDTH, default 8, buffer address width; DEPTH = 2**ADDR_WIDTH.
REQ-003 SHALL provide parameter TIMEOUT, default 1024, number of WAIT-state cycles allowed before a result must arrive.
REQ-004 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port wrEnIn  input  1  buffer write strobe.
REQ-007 SHALL have port wrAddrIn  input  ADDR_WIDTH  buffer write address.
REQ-008 SHALL have port wrDataIn  input  DATA_WIDTH  buffer write data.
REQ-009 SHALL have port startIn  input  1  packet start request.
REQ-010 SHALL have port lenIn  input  ADDR_WIDTH+1  packet length in words; legal range is 1..DEPTH.
REQ-011 SHALL have port busyOut  output  1  high in any state other than IDLE.
REQ-012 SHALL have port validOut  output  1  stream beat valid, to the accumulator.
REQ-013 SHALL have port lastOut  output  1  final beat of the packet.
REQ-014 SHALL have port dataOut  output  DATA_WIDTH  stream beat data.
REQ-015 SHALL have port resValidIn  input  1  accumulator result valid.
REQ-016 SHALL have port resDataIn  input  DATA_WIDTH  accumulator result.
REQ-017 SHALL have port doneOut  output  1  one-cycle pulse when a result has been captured.
REQ-018 SHALL have port resultOut  output  DATA_WIDTH  last captured result; held until the next capture.
REQ-019 SHALL have port errorOut  output  1  one-cycle pulse on an illegal length or on timeout.

Function
REQ-020 SHALL contain a DEPTH x DATA_WIDTH buffer with a synchronous write, and a synchronous read that has a one-cycle read latency.
REQ-021 SHALL write the buffer when wrEnIn=1 in IDLE; SHALL ignore wrEnIn while busyOut=1.
REQ-022 SHALL implement the FSM states IDLE, SEND and WAIT.
REQ-023 In IDLE, when startIn=1 and 1<=lenIn<=DEPTH, SHALL latch lenIn and move to SEND at that edge.
REQ-024 In IDLE, when startIn=1 and lenIn=0 or lenIn>DEPTH, SHALL pulse errorOut the next cycle and remain in IDLE.
REQ-025 SHALL ignore startIn while busyOut=1.
REQ-026 If startIn is sampled at edge E0, SHALL emit beat i (buf[i], i=0..len-1) with validOut=1 in the cycle after edge E0+2+i.
REQ-027 validOut SHALL be contiguous across the packet, with no bubbles; there is no backpressure input.
REQ-028 lastOut SHALL be 1 only on beat len-1; for len=1, validOut and lastOut SHALL be asserted in the same cycle.
REQ-029 When the registered lastOut beat is emitted, the FSM SHALL move to WAIT; validOut and lastOut SHALL be 0 on the following cycle.
REQ-030 dataOut SHALL be 0 whenever validOut=0.
REQ-031 In WAIT, on resValidIn=1 SHALL capture resDataIn into resultOut, pulse doneOut for exactly one cycle (the cycle after capture), and return to IDLE.
REQ-032 SHALL ignore resValidIn in IDLE and SEND.
REQ-033 WAIT SHALL count cycles; when TIMEOUT cycles elapse without resValidIn, SHALL pulse errorOut, leave resultOut unchanged, and return to IDLE.
REQ-034 If resValidIn arrives on the same edge the timeout expires, the result SHALL win (doneOut, no errorOut).
REQ-035 doneOut and errorOut SHALL never be asserted in the same cycle.
REQ-036 A new packet SHALL be startable on the first cycle after return to IDLE.

Reset
REQ-037 On rst=1, SHALL go to IDLE; busyOut, validOut, lastOut, doneOut and errorOut SHALL be 0; dataOut and resultOut SHALL be 0; the timeout counter SHALL be cleared.
REQ-038 Reset mid-SEND or mid-WAIT SHALL abort the packet with no further beats and no done or error pulse.
REQ-039 Reset SHALL NOT clear buffer contents.

Verification
REQ-040 Write 0x3F800000, 0x40000000, 0x40400000, 0x40800000 to addresses 0-3, start with len=4 -> four contiguous beats in that order, lastOut on 0x40800000; drive resValidIn with 0x41200000 -> resultOut=0x41200000 and a single doneOut pulse.
REQ-041 len=1 with buf[0]=0x3F800000 -> a single beat with validOut=lastOut=1; respond 0x3F800000 -> doneOut.
REQ-042 start with len=0, and separately with len=DEPTH+1 -> errorOut pulse, busyOut stays 0, no beats.
REQ-043 len=2 with no resValidIn -> errorOut exactly TIMEOUT cycles after entering WAIT; resultOut retains its prior value.
REQ-044 Assert rst during beat 2 of a len=8 packet -> validOut=0 next cycle; then a start with len=3 streams buf[0..2] correctly.
REQ-045 startIn and wrEnIn pulsed during SEND -> ignored: packet unchanged and buffer unchanged.

Source files
------------

// File: rtl/accum_stream_driver.sv
// Streams a packet of buffered single-precision words to an external accumulator,
// then waits (bounded by TIMEOUT) for the accumulated result and reports done/error.
module accum_stream_driver #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wrEnIn,
  input  logic [ADDR_WIDTH-1:0] wrAddrIn,
  input  logic [DATA_WIDTH-1:0] wrDataIn,
  input  logic                  startIn,
  input  logic [ADDR_WIDTH:0]   lenIn,
  output logic                  busyOut,
  output logic                  validOut,
  output logic                  lastOut,
  output logic [DATA_WIDTH-1:0] dataOut,
  input  logic                  resValidIn,
  input  logic [DATA_WIDTH-1:0] resDataIn,
  output logic                  doneOut,
  output logic [DATA_WIDTH-1:0] resultOut,
  output logic                  errorOut
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int LW    = ADDR_WIDTH + 1;
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q, rd_last_q;
  logic [LW-1:0]         len_q, len_d;
  logic [LW-1:0]         issue_q, issue_d;
  logic [TW-1:0]         timer_q, timer_d;

  logic start_ok_s, start_bad_s, rd_en_s, rd_last_s, res_hit_s, timeout_s;

  logic                  busy_q, valid_q, last_q, done_q, error_q;
  logic                  busy_d, valid_d, last_d, done_d, error_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, result_q, result_d;

  // Qualifying conditions shared by the FSM and the datapath
  always_comb begin
    start_ok_s  = (state_q == S_IDLE) && startIn && (lenIn != {LW{1'b0}}) && (lenIn <= DEPTH_L);
    start_bad_s = (state_q == S_IDLE) && startIn && !((lenIn != {LW{1'b0}}) && (lenIn <= DEPTH_L));
    rd_en_s     = (state_q == S_SEND) && (issue_q != len_q);
    rd_last_s   = (issue_q == (len_q - LW'(1)));
    res_hit_s   = (state_q == S_WAIT) && resValidIn;
    timeout_s   = (state_q == S_WAIT) && !resValidIn && (timer_q == TMO_LAST);
  end

  // Next-state logic; SEND ends on the cycle the last beat is on the bus
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok_s) state_d = S_SEND;
        else            state_d = S_IDLE;
      end
      S_SEND: begin
        if (last_q) state_d = S_WAIT;
        else        state_d = S_SEND;
      end
      S_WAIT: begin
        if (res_hit_s || timeout_s) state_d = S_IDLE;
        else                        state_d = S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read-issue counter, latched length and WAIT-cycle timer
  always_comb begin
    if (start_ok_s) len_d = lenIn;
    else            len_d = len_q;

    if (start_ok_s)   issue_d = {LW{1'b0}};
    else if (rd_en_s) issue_d = issue_q + LW'(1);
    else              issue_d = issue_q;

    if (state_q == S_WAIT) timer_d = timer_q + TW'(1);
    else                   timer_d = {TW{1'b0}};
  end

  // Next values of the registered outputs; result wins a tie with timeout
  always_comb begin
    busy_d  = (state_d != S_IDLE);
    valid_d = rd_valid_q;
    last_d  = rd_last_q;
    if (rd_valid_q) data_d = rd_data_q;
    else            data_d = {DATA_WIDTH{1'b0}};
    done_d  = res_hit_s;
    error_d = start_bad_s || timeout_s;
    if (res_hit_s) result_d = resDataIn;
    else           result_d = result_q;
  end

  // State and control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= {LW{1'b0}};
      issue_q    <= {LW{1'b0}};
      timer_q    <= {TW{1'b0}};
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      data_q     <= {DATA_WIDTH{1'b0}};
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      result_q   <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issue_q    <= issue_d;
      timer_q    <= timer_d;
      rd_valid_q <= rd_en_s;
      rd_last_q  <= rd_en_s && rd_last_s;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      data_q     <= data_d;
      done_q     <= done_d;
      error_q    <= error_d;
      result_q   <= result_d;
    end
  end

  // Packet buffer: contents survive reset, writes only accepted while idle
  always_ff @(posedge clk) begin
    if (wrEnIn && (state_q == S_IDLE)) begin
      mem_q[wrAddrIn] <= wrDataIn;
    end
    if (rd_en_s) begin
      rd_data_q <= mem_q[issue_q[ADDR_WIDTH-1:0]];
    end
  end

  assign busyOut   = busy_q;
  assign validOut  = valid_q;
  assign lastOut   = last_q;
  assign dataOut   = data_q;
  assign doneOut   = done_q;
  assign resultOut = result_q;
  assign errorOut  = error_q;

endmodule
